// File: rtl/sp_ram_init.sv
// Single-port RAM with byte enables, 1- or 2-cycle read latency, and a hardware
// init sweep that writes INIT_VAL to every word after reset or on clr.
module sp_ram_init #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 1024,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0,
    localparam int               AW       = $clog2(DEPTH),
    localparam int               BW       = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [BW-1:0]     req_be,
    input  logic              clr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              init_busy,
    output logic              addr_err
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST      = AW'(DEPTH - 1);

    state_t            state;
    logic [AW-1:0]     ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              in_range;
    logic              wr_acc;
    logic              rd_acc;
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;

    assign init_busy = (state == INIT);
    assign req_ready = (state == RUN);
    assign accept    = req_valid && req_ready;
    assign in_range  = {1'b0, req_addr} < DEPTH_EXT;
    assign wr_acc    = accept && req_we && in_range;
    assign rd_acc    = accept && !req_we;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (clr) begin
                        ptr <= '0;
                    end else if (ptr == LAST) begin
                        state <= RUN;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + AW'(1);
                    end
                end
                RUN: begin
                    if (clr) begin
                        state <= INIT;
                        ptr   <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // NOTE: the array has no reset; clearing it is the job of the init sweep.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[ptr] <= INIT_VAL;
        end else if (wr_acc) begin
            for (int i = 0; i < BW; i++) begin
                if (req_be[i]) mem[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    // First read stage samples the array at the accept edge; out-of-range reads return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            addr_err <= 1'b0;
        end else begin
            s1_valid <= rd_acc;
            addr_err <= accept && !in_range;
            if (rd_acc) s1_data <= in_range ? mem[req_addr] : '0;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rsp_valid <= 1'b0;
                rsp_rdata <= '0;
            end else begin
                rsp_valid <= s1_valid;
                if (s1_valid) rsp_rdata <= s1_data;
            end
        end
    end else begin : g_lat1
        assign rsp_valid = s1_valid;
        assign rsp_rdata = s1_data;
    end

endmodule
